io_port_responder: RTL

- Device-side responder for the CPU's IN/OUT instruction port.
- OUT path: a FIFO accepts words the CPU writes and drains them to a host sink over valid/ready.
- IN path: a one-word holding register is filled by a host source over valid/ready and returns a word to the CPU on each IN request.
- Raises stall to gate the CPU phase-counter enable while an OUT cannot be accepted or an IN has no data yet.

---
 rtl/io_port_pkg.sv | 12 +
 rtl/io_port_responder_if.sv | 32 +++
 rtl/sync_fifo_fwft.sv | 47 ++++
 rtl/io_port_responder.sv | 86 ++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// io_port_pkg: shared defaults and IN-path state encoding for the CPU IN/OUT port responder
package io_port_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_WAIT = 1'b1
    } in_state_t;

endpackage

// File: rtl/io_port_responder_if.sv
// io_port_responder_if: CPU IN/OUT strobes plus host tx/rx valid-ready channels
interface io_port_responder_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              out_wr;
    logic [DATA_W-1:0] out_data;
    logic              in_rd;
    logic [DATA_W-1:0] in_data;
    logic              in_ack;
    logic              stall;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    logic [LVL_W-1:0]  level;

    modport slave (
        input  out_wr, out_data, in_rd, tx_ready, rx_valid, rx_data,
        output in_data, in_ack, stall, tx_valid, tx_data, rx_ready, level
    );

    modport master (
        output out_wr, out_data, in_rd, tx_ready, rx_valid, rx_data,
        input  in_data, in_ack, stall, tx_valid, tx_data, rx_ready, level
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: synchronous first-word-fall-through FIFO; head word is visible on dout while non-empty
module sync_fifo_fwft #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [LVL_W-1:0]  level
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;

    // storage array, written on push only; contents are meaningless while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + LVL_W'(push) - LVL_W'(pop);
        end
    end

    assign empty = (count == '0);
    assign full  = (count == LVL_W'(DEPTH));
    assign level = count;
    // forcing zero while empty keeps stale words off the output after reset or drain
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_port_responder.sv
// io_port_responder: device side of the CPU IN/OUT port; OUT words buffered to host, IN words served from a holding register
module io_port_responder
    import io_port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input logic               clk,
    input logic               rst,
    io_port_responder_if.slave bus
);
    logic              push;
    logic              pop;
    logic              empty;
    logic              full;
    in_state_t         state;
    in_state_t         state_next;
    logic              buf_full;
    logic [DATA_W-1:0] buf_data;
    logic              req;
    logic              take_buf;
    logic              bypass;
    logic              capture;

    assign pop  = bus.tx_valid & bus.tx_ready;
    assign push = bus.out_wr & (!full | pop);

    sync_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(DEPTH)) out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.out_data),
        .dout  (bus.tx_data),
        .empty (empty),
        .full  (full),
        .level (bus.level)
    );

    assign bus.tx_valid = !empty;

    // an IN request is live only when no OUT competes and it is not already being acked this cycle
    assign req          = bus.in_rd & !bus.out_wr & !bus.in_ack;
    assign bus.rx_ready = !buf_full & !rst;
    assign capture      = bus.rx_valid & bus.rx_ready & !bypass;
    assign bus.stall    = !rst & ((bus.out_wr & full & !pop) | (bus.in_rd & !bus.in_ack));

    // IN state register
    always_ff @(posedge clk) begin
        state <= rst ? IN_IDLE : state_next;
    end

    // IN next-state: serve from buffer if loaded, else wait and bypass the first host word
    always_comb begin
        state_next = state;
        take_buf   = 1'b0;
        bypass     = 1'b0;
        if (!req) begin
            state_next = IN_IDLE;
        end else if (buf_full) begin
            take_buf   = 1'b1;
            state_next = IN_IDLE;
        end else if (state == IN_WAIT && bus.rx_valid) begin
            bypass     = 1'b1;
            state_next = IN_IDLE;
        end else begin
            state_next = IN_WAIT;
        end
    end

    // holding register and registered IN reply
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full    <= 1'b0;
            buf_data    <= '0;
            bus.in_ack  <= 1'b0;
            bus.in_data <= '0;
        end else begin
            bus.in_ack <= take_buf | bypass;
            if (take_buf | bypass) bus.in_data <= bypass ? bus.rx_data : buf_data;
            buf_full <= capture | (buf_full & !take_buf);
            if (capture) buf_data <= bus.rx_data;
        end
    end

endmodule
